fpu_issue_wb: RTL and testbench

- Initiator/collector for fixed-latency, valid-only FPU pipelines (feq, flt, fadd class units), which have no backpressure.
- Accepts operand requests from the core over valid/ready and drives the unit's valid/x1/x2 inputs.
- Carries each request's destination tag through a latency-matched delay line, pairs the unit's y/out_valid with that tag, and buffers results in a FIFO for writeback over valid/ready.
- Credit accounting ensures a result launched into the unit always has a FIFO slot.

---
 rtl/fpu_pkg.sv | 14 +
 rtl/fpu_result_fifo.sv | 47 ++++
 rtl/fpu_issue_wb.sv | 86 ++++++++
 tb/tb_fpu_issue_wb.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU issue/writeback types and constants.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fpu_pkg;
  localparam int          FP_W    = 32;
  localparam logic [31:0] FP_ONE  = 32'h3f800000;
  localparam logic [31:0] FP_ZERO = 32'h0;
  localparam int          TAG_W   = 5;

  typedef struct packed {
    logic [FP_W-1:0]  y;
    logic [TAG_W-1:0] tag;
  } fpu_result_t;
endpackage

// File: rtl/fpu_result_fifo.sv
// Generic synchronous FIFO with occupancy count and full/empty flags.
// Latency: a write is visible at the head the cycle after it lands.
// Backpressure: writes while full are dropped; reads while empty are ignored.
module fpu_result_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic                         sys_clk,
  input  logic                         rstn,
  input  logic                         wr_en,
  input  logic [W-1:0]                 wr_dat,
  input  logic                         rd_en,
  output logic [W-1:0]                 rd_dat,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_ok, rd_ok;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign wr_ok  = wr_en & ~full;
  assign rd_ok  = rd_en & ~empty;
  assign rd_dat = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap without compare logic.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_dat;
  end
endmodule

// File: rtl/fpu_issue_wb.sv
// Issues operands to a fixed-latency FPU unit and buffers tagged results for writeback.
// Latency: LATENCY+1 cycles minimum from request accept to wb_valid.
// Backpressure: credit-based; req_ready drops when inflight+buffered reaches DEPTH.
module fpu_issue_wb #(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 5
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             fu_valid,
  output logic [31:0]      fu_x1,
  output logic [31:0]      fu_x2,
  input  logic             fu_out_valid,
  input  logic [31:0]      fu_y,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_y,
  output logic [TAG_W-1:0] wb_tag,
  output logic             busy,
  output logic             err
);
  import fpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int RW    = FP_W + TAG_W;

  logic [LATENCY-1:0] dl_vld;
  logic [TAG_W-1:0]   dl_tag [LATENCY];
  logic [CNT_W-1:0]   inflight, occupancy, credits;
  logic               issue, capture, pop, fifo_full, fifo_empty;
  logic [RW-1:0]      head;

  // Credits come from registered counts only, so a pop frees its slot next cycle.
  assign credits   = CNT_W'(DEPTH) - inflight - occupancy;
  assign req_ready = rstn & (credits != '0);
  assign issue     = req_valid & req_ready;
  assign fu_valid  = issue;
  assign fu_x1     = req_x1;
  assign fu_x2     = req_x2;
  assign capture   = fu_out_valid & dl_vld[LATENCY-1];
  assign pop       = wb_valid & wb_ready;
  assign wb_valid  = ~fifo_empty;
  assign wb_y      = head[RW-1:TAG_W];
  assign wb_tag    = head[TAG_W-1:0];
  assign busy      = (inflight != '0) | ~fifo_empty;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      dl_vld   <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      dl_vld[0] <= issue;
      for (int i = 1; i < LATENCY; i++) dl_vld[i] <= dl_vld[i-1];
      inflight <= inflight + CNT_W'(issue) - CNT_W'(capture);
      // Unit and delay line must agree every cycle; a full FIFO on capture loses data.
      if ((fu_out_valid != dl_vld[LATENCY-1]) || (capture && fifo_full)) err <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    dl_tag[0] <= req_tag;
    for (int i = 1; i < LATENCY; i++) dl_tag[i] <= dl_tag[i-1];
  end

  fpu_result_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .wr_en   (capture),
    .wr_dat  ({fu_y, dl_tag[LATENCY-1]}),
    .rd_en   (pop),
    .rd_dat  (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (occupancy)
  );
endmodule

// File: tb/tb_fpu_issue_wb.sv
// Scoreboard bench for fpu_issue_wb with a 1-cycle feq unit model.
module tb_fpu_issue_wb;
  import fpu_pkg::*;

  logic        sys_clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready;
  logic [31:0] req_x1, req_x2;
  logic [4:0]  req_tag;
  logic        fu_valid;
  logic [31:0] fu_x1, fu_x2;
  logic        fu_out_valid;
  logic [31:0] fu_y;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_y;
  logic [4:0]  wb_tag;
  logic        busy, err;

  logic        inject;
  logic        model_vld;
  logic [31:0] model_y;
  logic [31:0] cur_exp_y;

  int n_chk = 0;
  int n_err = 0;
  fpu_result_t exp_q[$];
  fpu_result_t e_pop;

  // Directed vectors with hand-computed feq results.
  logic [31:0] vx1 [8] = '{32'h3f800000, 32'h3f800000, 32'h00000000, 32'h40400000,
                           32'h40400000, 32'h41200000, 32'h00000000, 32'hbf800000};
  logic [31:0] vx2 [8] = '{32'h3f800000, 32'h40000000, 32'h00000000, 32'h40400000,
                           32'hc0400000, 32'h41200000, 32'h3f800000, 32'hbf800000};
  logic [31:0] vy  [8] = '{32'h3f800000, 32'h00000000, 32'h3f800000, 32'h3f800000,
                           32'h00000000, 32'h3f800000, 32'h00000000, 32'h3f800000};

  always #5 sys_clk = ~sys_clk;

  fpu_issue_wb #(.LATENCY(1), .DEPTH(4), .TAG_W(5)) dut (
    .sys_clk      (sys_clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_x1       (req_x1),
    .req_x2       (req_x2),
    .req_tag      (req_tag),
    .fu_valid     (fu_valid),
    .fu_x1        (fu_x1),
    .fu_x2        (fu_x2),
    .fu_out_valid (fu_out_valid),
    .fu_y         (fu_y),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_y         (wb_y),
    .wb_tag       (wb_tag),
    .busy         (busy),
    .err          (err)
  );

  // One-cycle feq unit, reset together with the block.
  always @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      model_vld <= 1'b0;
      model_y   <= 32'h0;
    end else begin
      model_vld <= fu_valid;
      model_y   <= (fu_x1 == fu_x2) ? FP_ONE : FP_ZERO;
    end
  end
  assign fu_out_valid = model_vld | inject;
  assign fu_y         = model_y;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pop/compare on writeback, push on accepted request.
  always @(negedge sys_clk) begin
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_pop: unexpected writeback tag=%0h y=%0h", wb_tag, wb_y);
        end else begin
          e_pop = exp_q.pop_front();
          chk("sb_y", 64'(wb_y), 64'(e_pop.y));
          chk("sb_tag", 64'(wb_tag), 64'(e_pop.tag));
        end
      end
      if (req_valid && req_ready) exp_q.push_back('{y: cur_exp_y, tag: req_tag});
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic set_req(input int v, input int t);
    req_valid = 1'b1;
    req_x1    = vx1[v];
    req_x2    = vx2[v];
    cur_exp_y = vy[v];
    req_tag   = 5'(t);
  endtask

  task automatic drain();
    wb_ready = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || wb_valid || busy); i++) tick();
    #1;
    chk("drain_busy", 64'(busy), 64'd0);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int acc, lows, first_low;
    rstn = 1'b0; req_valid = 1'b0; req_x1 = '0; req_x2 = '0; req_tag = '0;
    wb_ready = 1'b1; inject = 1'b0; cur_exp_y = '0;
    repeat (2) @(posedge sys_clk);
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fu_valid", 64'(fu_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    #5 rstn = 1'b1;
    tick();
    chk("rel_req_ready", 64'(req_ready), 64'd1);

    // Single issue: fu_valid same cycle, writeback two cycles later.
    set_req(0, 3);
    #1;
    chk("t1_fu_valid", 64'(fu_valid), 64'd1);
    chk("t1_fu_x1", 64'(fu_x1), 64'h3f800000);
    tick(); req_valid = 1'b0; #1;
    chk("t1_wb_early", 64'(wb_valid), 64'd0);
    tick(); #1;
    chk("t1_wb_valid", 64'(wb_valid), 64'd1);
    chk("t1_wb_y", 64'(wb_y), 64'h3f800000);
    chk("t1_wb_tag", 64'(wb_tag), 64'd3);
    tick(); #1;
    chk("t1_wb_done", 64'(wb_valid), 64'd0);

    // Back-to-back tags 1..4 with writeback always ready.
    for (int v = 1; v <= 4; v++) begin
      set_req(v, v);
      #1;
      chk("t2_req_ready", 64'(req_ready), 64'd1);
      tick();
    end
    req_valid = 1'b0; #1;
    chk("t2_wb_tag3", 64'(wb_valid), 64'd1);
    tick(); #1;
    chk("t2_wb_tag4_vld", 64'(wb_valid), 64'd1);
    chk("t2_wb_tag4", 64'(wb_tag), 64'd4);
    tick(); #1;
    chk("t2_wb_idle", 64'(wb_valid), 64'd0);
    chk("t2_err", 64'(err), 64'd0);

    // Credit exhaustion with writeback stalled.
    wb_ready = 1'b0; acc = 0; lows = 0; first_low = -1;
    for (int i = 0; i < 8; i++) begin
      set_req((acc + 4) % 8, 8 + acc);
      #1;
      if (req_ready) acc++;
      else begin
        lows++;
        if (first_low < 0) first_low = i;
      end
      tick();
    end
    req_valid = 1'b0; #1;
    chk("t3_accepts", 64'(acc), 64'd4);
    chk("t3_first_low", 64'(first_low), 64'd4);
    chk("t3_lows", 64'(lows), 64'd4);
    chk("t3_full_vld", 64'(wb_valid), 64'd1);
    chk("t3_full_head", 64'(wb_tag), 64'd8);
    chk("t3_full_ready", 64'(req_ready), 64'd0);
    wb_ready = 1'b1; #1;
    chk("t3_pop_ready_same", 64'(req_ready), 64'd0);
    tick(); wb_ready = 1'b0; #1;
    chk("t3_pop_ready_next", 64'(req_ready), 64'd1);
    chk("t3_pop_head", 64'(wb_tag), 64'd9);
    drain();

    // Capture and pop in the same cycle at occupancy 1.
    set_req(5, 20);
    tick();
    set_req(6, 21);
    tick(); req_valid = 1'b0; #1;
    chk("t4_vld_a", 64'(wb_valid), 64'd1);
    chk("t4_tag_a", 64'(wb_tag), 64'd20);
    tick(); #1;
    chk("t4_vld_b", 64'(wb_valid), 64'd1);
    chk("t4_tag_b", 64'(wb_tag), 64'd21);
    tick(); #1;
    chk("t4_idle", 64'(wb_valid), 64'd0);

    // Spurious unit result.
    chk("t5_err_pre", 64'(err), 64'd0);
    inject = 1'b1;
    tick(); inject = 1'b0; #1;
    chk("t5_err_set", 64'(err), 64'd1);
    chk("t5_wb_valid", 64'(wb_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("t5_err_sticky", 64'(err), 64'd1);

    // Reset with one inflight and three buffered.
    wb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_req(k + 4, 24 + k);
      tick();
    end
    req_valid = 1'b0; #1;
    chk("t6_pre_busy", 64'(busy), 64'd1);
    chk("t6_pre_wb", 64'(wb_valid), 64'd1);
    rstn = 1'b0; #1;
    chk("t6_rst_wb", 64'(wb_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_err", 64'(err), 64'd0);
    chk("t6_rst_ready", 64'(req_ready), 64'd0);
    #3 rstn = 1'b1;
    tick();
    chk("t6_rel_ready", 64'(req_ready), 64'd1);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      set_req(acc, 28 + acc);
      #1;
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    chk("t6_credits", 64'(acc), 64'd4);
    drain();
    chk("t6_err_end", 64'(err), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
